// File: rtl/calc_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : calc_cmd_driver
// Purpose  : Initiator-side driver for the 8-bit accumulator calculator.
//            Queues {op, operand, clear} commands in a small FIFO, sequences
//            the calculator NumIn/OpIn/Enter/Reset pins with a setup cycle
//            ahead of the Enter strobe, captures NumOut after each operation
//            and returns it on a valid/ready result port.
// Ports    : clock, Reset                      - clock / sync active-high reset
//            cmd_valid/ready/op/operand/clear  - command input port
//            res_valid/ready/value             - result output port
//            NumIn, OpIn, Enter, CalcReset     - calculator control pins
//            NumOut                            - calculator accumulator value
//            err_mismatch                      - sticky shadow-check error
// Options  : CALC_CMD_DRIVER_SHADOW_EN - enables the internal shadow
//            accumulator that cross-checks NumOut; when undefined the
//            err_mismatch output is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module calc_cmd_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_value,
  output logic [WIDTH-1:0] NumIn,
  output logic [1:0]       OpIn,
  output logic             Enter,
  output logic             CalcReset,
  input  logic [WIDTH-1:0] NumOut,
  output logic             err_mismatch
);

  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = WIDTH + 3;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit so full and empty can be
  // told apart when the index bits match.
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               head_clear;
  logic [1:0]         head_op;
  logic [WIDTH-1:0]   head_operand;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  assign head         = fifo_mem[rd_ptr[ADDR_W-1:0]];
  assign head_clear   = head[ENTRY_W-1];
  assign head_op      = head[WIDTH+1:WIDTH];
  assign head_operand = head[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr[ADDR_W-1:0]] <= {cmd_clear, cmd_op, cmd_operand};
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_SETTLE = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t state;
  state_t next_state;
  logic   load_cmd;
  logic   clear_strobe;
  logic   enter_req;
  logic   capture;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    load_cmd     = 1'b0;
    clear_strobe = 1'b0;
    enter_req    = 1'b0;
    capture      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_clear) begin
            next_state = S_CLEAR;
          end else begin
            load_cmd   = 1'b1;
            next_state = S_SETUP;
          end
        end
      end
      S_CLEAR: begin
        clear_strobe = 1'b1;
        next_state   = S_IDLE;
      end
      S_SETUP: begin
        next_state = S_STROBE;
      end
      S_STROBE: begin
        enter_req  = 1'b1;
        next_state = S_SETTLE;
      end
      S_SETTLE: begin
        capture    = 1'b1;
        next_state = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Enter is masked by Reset so a reset landing in STROBE never overlaps the
  // calculator's own reset pulse.
  assign Enter     = enter_req && !Reset;
  assign CalcReset = Reset || clear_strobe;
  assign res_valid = (state == S_RESULT);

  // Operand/op registers change only on a pop, so they are stable through
  // SETUP, STROBE and SETTLE.
  always_ff @(posedge clock) begin
    if (Reset) begin
      NumIn     <= '0;
      OpIn      <= 2'b00;
      res_value <= '0;
    end else begin
      if (load_cmd) begin
        NumIn <= head_operand;
        OpIn  <= head_op;
      end
      if (capture) begin
        res_value <= NumOut;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional shadow accumulator cross-check
  // --------------------------------------------------------------------------
`ifdef CALC_CMD_DRIVER_SHADOW_EN
  logic [WIDTH-1:0] shadow_acc;
  logic             err_flag;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] val,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = acc + val;
      2'b01:   r = acc - val;
      2'b10:   r = acc | val;
      default: r = {{(WIDTH-1){1'b0}}, (acc == val)};
    endcase
    return r;
  endfunction

  // The shadow updates on the same edge the calculator does (end of STROBE),
  // so in SETTLE both should hold the same value.
  always_ff @(posedge clock) begin
    if (Reset) begin
      shadow_acc <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (clear_strobe) begin
        shadow_acc <= '0;
      end else if (enter_req) begin
        shadow_acc <= apply_op(shadow_acc, NumIn, OpIn);
      end
      if (capture && (NumOut != shadow_acc)) begin
        err_flag <= 1'b1;
      end
    end
  end

  assign err_mismatch = err_flag;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire
